// File: rtl/riego_pkg.sv
// Shared types and constants for the irrigation controller: FSM states and
// per-plant-type humidity hysteresis thresholds (index = tipo_planta).
package riego_pkg;

    localparam int CANAL_W = 3;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        SELECCION = 2'd1,
        RIEGO     = 2'd2,
        PAUSA     = 2'd3
    } estado_t;

    // Start watering below UMBRAL_BAJO, stop at or above UMBRAL_ALTO.
    localparam logic [15:0] UMBRAL_BAJO [16] = '{
        16'h0300, 16'h0200, 16'h0400, 16'h0500,
        16'h0250, 16'h0350, 16'h0450, 16'h0180,
        16'h0600, 16'h0700, 16'h0100, 16'h0280,
        16'h0380, 16'h0480, 16'h0580, 16'h0680
    };

    localparam logic [15:0] UMBRAL_ALTO [16] = '{
        16'h0600, 16'h0500, 16'h0800, 16'h0900,
        16'h0550, 16'h0650, 16'h0750, 16'h0400,
        16'h0A00, 16'h0B00, 16'h0300, 16'h0580,
        16'h0680, 16'h0780, 16'h0880, 16'h0C00
    };

endpackage

// File: rtl/divisor_tick.sv
// One-second tick generator: free-running CLK_HZ-cycle counter with a
// synchronous restart so the first period after `reinicio` is exactly CLK_HZ cycles.
module divisor_tick #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic reinicio,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        if (reinicio || (cnt_q == CNT_FIN)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_FIN);

endmodule

// File: rtl/controlador_riego.sv
// Multi-channel irrigation controller: round-robin pump grant, hysteresis, post-watering
// pause; optional on-time watchdog with sticky per-channel fault under RIEGO_WATCHDOG_EN.
module controlador_riego
    import riego_pkg::*;
#(
    parameter int N_CANALES = 4,
    parameter int ANCHO_HUM = 12,
    parameter int CLK_HZ    = 50_000_000,
    parameter int T_MAX_S   = 30,
    parameter int T_PAUSA_S = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dato_valido,
    input  logic [CANAL_W-1:0]   canal,
    input  logic [ANCHO_HUM-1:0] humedad,
    input  logic [3:0]           tipo_planta,
    input  logic [N_CANALES-1:0] modulo_presente,
    output logic [N_CANALES-1:0] bomba,
    output logic [CANAL_W-1:0]   canal_activo,
    output logic                 ocupado,
    output logic                 alarma,
    output logic [N_CANALES-1:0] falla
);

    localparam int SEG_MAX = (T_MAX_S > T_PAUSA_S) ? T_MAX_S : T_PAUSA_S;
    localparam int SEG_W   = $clog2(SEG_MAX + 1);

    estado_t              estado_q, estado_d;
    logic [ANCHO_HUM-1:0] hum_q  [N_CANALES];
    logic [ANCHO_HUM-1:0] hum_d  [N_CANALES];
    logic [3:0]           tipo_q [N_CANALES];
    logic [3:0]           tipo_d [N_CANALES];
    logic [N_CANALES-1:0] falla_q, falla_d;
    logic [N_CANALES-1:0] bomba_q, bomba_d;
    logic [CANAL_W-1:0]   canal_activo_q, canal_activo_d;
    logic [CANAL_W-1:0]   ptr_q, ptr_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic                 ocupado_q, ocupado_d;
    logic                 alarma_q, alarma_d;

    logic [N_CANALES-1:0] necesita;
    logic [N_CANALES-1:0] lleno;
    logic [CANAL_W-1:0]   concesion;
    logic                 hay_concesion;
    logic                 presente_act;
    logic                 lleno_act;
    logic                 limite;
    logic                 fin_pausa;
    logic                 tick;
    logic                 reinicio;

    divisor_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .reinicio (reinicio),
        .tick     (tick)
    );

    // Sample capture and per-channel demand from the stored values.
    always_comb begin
        for (int c = 0; c < N_CANALES; c++) begin
            hum_d[c]  = hum_q[c];
            tipo_d[c] = tipo_q[c];
            if (dato_valido && (canal == CANAL_W'(c))) begin
                hum_d[c]  = humedad;
                tipo_d[c] = tipo_planta;
            end
            necesita[c] = (hum_q[c] < ANCHO_HUM'(UMBRAL_BAJO[tipo_q[c]]))
                          && modulo_presente[c] && !falla_q[c];
            lleno[c]    = (hum_q[c] >= ANCHO_HUM'(UMBRAL_ALTO[tipo_q[c]]));
        end
    end

    // Round-robin search starting at ptr_q, plus status of the channel being watered.
    always_comb begin
        hay_concesion = 1'b0;
        concesion     = '0;
        presente_act  = 1'b0;
        lleno_act     = 1'b0;
        for (int i = 0; i < N_CANALES; i++) begin
            for (int c = 0; c < N_CANALES; c++) begin
                if (!hay_concesion && necesita[c] && (c == (int'(ptr_q) + i) % N_CANALES)) begin
                    hay_concesion = 1'b1;
                    concesion     = CANAL_W'(c);
                end
            end
            if (canal_activo_q == CANAL_W'(i)) begin
                presente_act = modulo_presente[i];
                lleno_act    = lleno[i];
            end
        end
    end

`ifdef RIEGO_WATCHDOG_EN
    assign limite = tick && (seg_q == SEG_W'(T_MAX_S - 1));
`else
    assign limite = 1'b0;
`endif
    assign fin_pausa = tick && (seg_q == SEG_W'(T_PAUSA_S - 1));

    always_comb begin
        estado_d       = estado_q;
        canal_activo_d = canal_activo_q;
        ptr_d          = ptr_q;
        falla_d        = falla_q;
        case (estado_q)
            REPOSO: begin
                if (|necesita) begin
                    estado_d = SELECCION;
                end
            end
            SELECCION: begin
                if (hay_concesion) begin
                    estado_d       = RIEGO;
                    canal_activo_d = concesion;
                    ptr_d          = CANAL_W'((int'(concesion) + 1) % N_CANALES);
                end else begin
                    estado_d = REPOSO;
                end
            end
            RIEGO: begin
                // Removal outranks the threshold, which outranks the timeout.
                if (!presente_act || lleno_act) begin
                    estado_d = PAUSA;
                end else if (limite) begin
                    estado_d = PAUSA;
                    for (int c = 0; c < N_CANALES; c++) begin
                        if (canal_activo_q == CANAL_W'(c)) begin
                            falla_d[c] = 1'b1;
                        end
                    end
                end
            end
            PAUSA: begin
                if (fin_pausa) begin
                    estado_d = REPOSO;
                end
            end
            default: estado_d = REPOSO;
        endcase

        if (estado_d != estado_q) begin
            seg_d = '0;
        end else if (tick) begin
            seg_d = seg_q + 1'b1;
        end else begin
            seg_d = seg_q;
        end
    end

    always_comb begin
        reinicio  = (estado_d != estado_q) && ((estado_d == RIEGO) || (estado_d == PAUSA));
        ocupado_d = (estado_d != REPOSO);
        alarma_d  = (estado_q == SELECCION) && (estado_d == RIEGO);
        for (int c = 0; c < N_CANALES; c++) begin
            bomba_d[c] = (estado_d == RIEGO) && (canal_activo_d == CANAL_W'(c));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q       <= REPOSO;
            canal_activo_q <= '0;
            ptr_q          <= '0;
            seg_q          <= '0;
            falla_q        <= '0;
            bomba_q        <= '0;
            ocupado_q      <= 1'b0;
            alarma_q       <= 1'b0;
            for (int c = 0; c < N_CANALES; c++) begin
                hum_q[c]  <= '1;
                tipo_q[c] <= '0;
            end
        end else begin
            estado_q       <= estado_d;
            canal_activo_q <= canal_activo_d;
            ptr_q          <= ptr_d;
            seg_q          <= seg_d;
            falla_q        <= falla_d;
            bomba_q        <= bomba_d;
            ocupado_q      <= ocupado_d;
            alarma_q       <= alarma_d;
            for (int c = 0; c < N_CANALES; c++) begin
                hum_q[c]  <= hum_d[c];
                tipo_q[c] <= tipo_d[c];
            end
        end
    end

    assign bomba        = bomba_q;
    assign canal_activo = canal_activo_q;
    assign ocupado      = ocupado_q;
    assign alarma       = alarma_q;
    assign falla        = falla_q;

endmodule
